// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the bin2bcd converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE  = 4'h9;

  // 10^n as a 64-bit constant; valid for n <= 19
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_add3.sv
// Double-dabble nibble corrector: add 3 to any BCD digit of 5 or more.
module bin2bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  // 4-bit correction, no carry out of the nibble
  always_comb begin
    adj = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  end

endmodule

// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional macro BIN2BCD_BLANK_EN: leading-zero digits are driven as 4'hF.
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SW    = BCD_W + BIN_W;
  localparam int unsigned CW    = $clog2(BIN_W + 1);

  // Overflow is only possible when 10^DIGITS fits below 2^BIN_W
  localparam logic [63:0]    P10    = pow10(DIGITS);
  localparam bit             OVF_EN = (BIN_W < 64) && (P10 < (64'd1 << BIN_W));
  localparam logic [BIN_W:0] MAX    = (BIN_W + 1)'(P10 - 64'd1);

  state_t           state;
  logic [SW-1:0]    scratch;
  logic [CW-1:0]    cnt;
  logic             ovf_q;

  logic [BCD_W-1:0] corr_c;
  logic [SW-1:0]    shifted_c;
  logic [BCD_W-1:0] result_c;
  logic [BCD_W-1:0] disp_c;
  logic             ovf_c;

  // One corrector per BCD digit of the scratch register
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bin2bcd_add3 u_add3 (
      .nib (scratch[BIN_W + 4*g +: 4]),
      .adj (corr_c[4*g +: 4])
    );
  end

  // Corrected BCD field above the untouched binary field, shifted by one
  always_comb begin
    shifted_c = {corr_c, scratch[BIN_W-1:0]} << 1;
    result_c  = shifted_c[SW-1:BIN_W];
    ovf_c     = OVF_EN && ({1'b0, bin} > MAX);
  end

`ifdef BIN2BCD_BLANK_EN
  logic seen_c;

  // Blank every zero digit above the most significant non-zero one; digit 0 always shows
  always_comb begin
    disp_c = result_c;
    seen_c = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (!seen_c && (result_c[4*i +: 4] == 4'h0)) begin
        disp_c[4*i +: 4] = BCD_BLANK;
      end else begin
        seen_c = 1'b1;
      end
    end
  end
`else
  // Leading zeros shown as 0
  always_comb begin
    disp_c = result_c;
  end
`endif

  // Conversion FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      scratch  <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= {{BCD_W{1'b0}}, bin};
            cnt     <= CW'(BIN_W);
            ovf_q   <= ovf_c;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted_c;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= ovf_q ? {DIGITS{BCD_NINE}} : disp_c;
            overflow <= ovf_q;
            state    <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            scratch <= {{BCD_W{1'b0}}, bin};
            cnt     <= CW'(BIN_W);
            ovf_q   <= ovf_c;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd.sv
// Self-checking bench for bin2bcd (BIN_W=14, DIGITS=4) against a decimal-arithmetic model.
module tb_bin2bcd;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [BIN_W-1:0]  bin;
  logic              busy;
  logic              done;
  logic [15:0]       bcd;
  logic              overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;

  bin2bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected display word from plain decimal arithmetic
  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int d[4];
    int t;
    int top;
    if (v > 9999) return 16'h9999;
    t = v;
    for (int i = 0; i < 4; i++) begin
      d[i] = t % 10;
      t = t / 10;
    end
`ifdef BIN2BCD_BLANK_EN
    top = 0;
    for (int i = 0; i < 4; i++) if (d[i] != 0) top = i;
    for (int i = 1; i < 4; i++) if (i > top) d[i] = 15;
`else
    top = 0;
`endif
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(d[i]);
    return r;
  endfunction

  // Issue start with v, wait for done; leaves the bench in the DONE cycle
  task automatic conv(input int v, input string tag);
    int n;
    int nb;
    start = 1'b1;
    bin   = BIN_W'(v);
    @(posedge clk); #1;
    start = 1'b0;
    n  = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd14);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd14);
    check({tag, "_bcd"}, 32'(bcd), 32'(model_bcd(v)));
    check({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
    last_done_cyc = cyc;
  endtask

  // One cycle after done: pulse is gone and the result holds
  task automatic after_done(input int v, input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(bcd), 32'(model_bcd(v)));
  endtask

  initial begin
    int d0;
    int c1;
    int v;
    int directed[10] = '{1234, 9999, 10000, 16383, 0, 1, 42, 1000, 12000, 9};

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    #12 rst = 1'b0;
    @(posedge clk); #1;

    foreach (directed[i]) begin
      conv(directed[i], $sformatf("dir%0d", directed[i]));
      after_done(directed[i], $sformatf("dir%0d", directed[i]));
    end

    // Back-to-back: start held in the DONE cycle
    conv(7, "b2b_first");
    c1 = last_done_cyc;
    conv(305, "b2b_second");
    check("b2b_gap", 32'(last_done_cyc - c1), 32'd15);
    after_done(305, "b2b_second");

    // start during SHIFT is ignored
    d0 = done_cnt;
    start = 1'b1; bin = BIN_W'(555);
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; start = 1'b1; bin = BIN_W'(999);
    @(posedge clk); #1; start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("shift_start_done_count", 32'(done_cnt - d0), 32'd1);
    check("shift_start_bcd", 32'(bcd), 32'(model_bcd(555)));

    // Asynchronous reset in the middle of a conversion
    start = 1'b1; bin = BIN_W'(4321);
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    @(negedge clk); rst = 1'b0;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_bcd_hold", 32'(bcd), 32'd0);
    conv(0, "post_rst_zero");
    after_done(0, "post_rst_zero");

    // Random values across the full input range
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(16383, 0));
      conv(v, $sformatf("rnd%0d", i));
      if (($urandom & 1) == 0) after_done(v, $sformatf("rnd%0d", i));
    end
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
